uart_tx_feeder: RTL
===================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, meaning byte-buffer entries; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter POLL_GAP, default 4, meaning clk cycles waited before re-reading status after TX-FIFO-full.
REQ-003 Parameter INIT_CTRL, default 1, meaning 1 = issue a control-register write after reset, 0 = skip it.
REQ-004 Clocking: one clock, clk; reset rst is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 data  in  8  byte to transmit.
REQ-008 valid  in  1  data is valid.
REQ-009 ready  out  1  block accepts data this cycle.
REQ-010 awaddr  out  4  AXI-Lite write address.
REQ-011 awvalid / awready  out / in  1 each  AXI-Lite write-address handshake.
REQ-012 wdata  out  32  AXI-Lite write data.
REQ-013 wstrb  out  4  write strobes; constant 4'b1111.
REQ-014 wvalid / wready  out / in  1 each  AXI-Lite write-data handshake.
REQ-015 bresp  in  2  write response code.
REQ-016 bvalid / bready  in / out  1 each  AXI-Lite write-response handshake.
REQ-017 araddr  out  4  AXI-Lite read address.
REQ-018 arvalid / arready  out / in  1 each  AXI-Lite read-address handshake.
REQ-019 rdata  in  32  read data; bit3 = UART TX FIFO full.
REQ-020 rresp  in  2  read response code.
REQ-021 rvalid / rready  in / out  1 each  AXI-Lite read-data handshake.
REQ-022 busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-023 err  out  1  sticky flag: any non-zero bresp or rresp seen.

Function
REQ-024 Byte FIFO: push on valid&&ready; ready=(count<FIFO_DEPTH); bytes SHALL be written out in strict acceptance order with no loss or duplication.
REQ-025 All AXI outputs SHALL be registered; address and data SHALL be held stable while the corresponding valid is high.
REQ-026 FSM states: INIT_W, INIT_B, IDLE, AR, R, GAP, W, B.
REQ-027 After reset release: INIT_CTRL=1 -> INIT_W; INIT_CTRL=0 -> IDLE.
REQ-028 INIT_W: awaddr=0xC, wdata=0x00000003; otherwise behaves as W, then INIT_B, which behaves as B without a pop, then IDLE.
REQ-029 IDLE: FIFO non-empty -> AR; arvalid SHALL rise after the second rising edge following the accept edge of the first byte into an empty idle block.
REQ-030 AR: araddr=0x8, arvalid=1 until arready, then R with rready=1.
REQ-031 R on rvalid: rresp!=0 -> set err, go GAP; else rdata[3]=1 -> GAP; else -> W.
REQ-032 GAP: wait exactly POLL_GAP cycles, then AR.
REQ-033 W: awaddr=0x4, wdata={24'h0, FIFO head}; awvalid and wvalid rise in the same cycle, and each drops the cycle after its own handshake; when both are done -> B.
REQ-034 B: bready=1; on bvalid, pop the FIFO head regardless of bresp; bresp!=0 sets err; -> IDLE.
REQ-035 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-036 The FIFO head SHALL not change between W entry and the B pop.
REQ-037 err SHALL stay set until reset.

Reset
REQ-038 rst low SHALL immediately force: state=IDLE; FIFO empty; awvalid, wvalid, arvalid, bready, rready, err, busy = 0; awaddr, araddr, wdata = 0; ready=1; any in-flight byte is discarded.
REQ-039 Only after rst deasserts, INIT_CTRL decides between INIT_W and IDLE.

Verification
REQ-040 Reset, INIT_CTRL=1, slave always ready, OKAY responses -> exactly one write: addr 0xC, data 0x3; then busy=0.
REQ-041 Push 0x41, status rdata=0x4 -> read at 0x8, write addr 0x4 data 0x00000041, pop on bvalid, busy=0.
REQ-042 Status rdata=0x8 on three reads, then 0x0 -> three GAP waits of POLL_GAP cycles each, then exactly one write of the byte.
REQ-043 awready=0, push 17 bytes -> ready low after the 16th accept, 17th byte not taken; release awready -> 16 writes in order.
REQ-044 bresp=2'b10 on the first byte -> err=1 and stays 1, byte popped, second byte still written.
REQ-045 rst low during W with awvalid=1 -> awvalid=0 at once, FIFO empty, ready=1; no further writes until a new push.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Buffers bytes in a small FIFO and feeds them one at a time to an AXI-Lite UART,
// polling its TX-FIFO-full status bit before every data write.
module uart_tx_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_GAP   = 4,
    parameter bit INIT_CTRL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic        ready,
    output logic [3:0]  awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        busy,
    output logic        err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [3:0]       CTRL_ADDR = 4'hC;
    localparam logic [3:0]       STAT_ADDR = 4'h8;
    localparam logic [3:0]       TXD_ADDR  = 4'h4;
    localparam logic [31:0]      CTRL_INIT = 32'h0000_0003;

    typedef enum logic [2:0] {
        S_INIT_W, S_INIT_B, S_IDLE, S_AR, S_R, S_GAP, S_W, S_B
    } state_t;

    state_t           state;
    logic             init_pending;
    logic             aw_done;
    logic             w_done;
    logic [GAP_W-1:0] gap_cnt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       head;
    logic             push;
    logic             pop;
    logic             aw_fin;
    logic             w_fin;
    logic             unused_rdata;

    assign ready  = (count < DEPTH_C);
    assign push   = valid && ready;
    assign pop    = (state == S_B) && bvalid && bready;
    assign head   = mem[rd_ptr];
    assign busy   = (count != '0) || (state != S_IDLE);
    assign wstrb  = 4'b1111;
    assign aw_fin = aw_done || (awvalid && awready);
    assign w_fin  = w_done || (wvalid && wready);

    assign unused_rdata = ^{rdata[31:4], rdata[2:0]};

    // NOTE: storage array has no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            init_pending <= INIT_CTRL;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wdata        <= '0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            err          <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (init_pending) begin
                        init_pending <= 1'b0;
                        awaddr       <= CTRL_ADDR;
                        wdata        <= CTRL_INIT;
                        awvalid      <= 1'b1;
                        wvalid       <= 1'b1;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        state        <= S_INIT_W;
                    end else if (count != '0) begin
                        state <= S_AR;
                    end
                end

                // arvalid is raised one cycle after entry, then held until accepted.
                S_AR: begin
                    if (!arvalid) begin
                        araddr  <= STAT_ADDR;
                        arvalid <= 1'b1;
                    end else if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rresp != 2'b00 || rdata[3]) begin
                            if (rresp != 2'b00) begin
                                err <= 1'b1;
                            end
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            awaddr  <= TXD_ADDR;
                            wdata   <= {24'h0, head};
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= S_W;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_AR;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                // Address and data channels complete independently; leave once both are done.
                S_W, S_INIT_W: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= (state == S_W) ? S_B : S_INIT_B;
                    end
                end

                S_B, S_INIT_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
